// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the multi-cycle data memory responder: FSM state
// encodings, word width, default base address and the address legality check.
package data_mem_responder_pkg;

   localparam int          WORD_W            = 32;
   localparam int          CNT_W             = 4;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h7FF0_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // The compare is done on 33 bits so that a window ending right at
   // 32'hFFFFFFFC cannot wrap around and accept low addresses.
   function automatic logic addrLegal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] lastWord);
      logic [32:0] wideAddr;
      wideAddr = {1'b0, addr};
      return (wideAddr >= {1'b0, base}) && (wideAddr <= lastWord) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// Word-organised storage behind the responder: synchronous write and a
// registered read port that only updates when a read is requested, so the
// last loaded word stays on the output between loads.
module mem_word_array
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_q;

   // Commit stores and capture load data on the same edge; contents are never reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[idx_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the pipeline data port. Accepts one load or
// store over valid/ready, answers LATENCY cycles later with a one-cycle
// resp_valid pulse, and raises busy while a request is in flight so the
// hazard unit can stall the earlier stages.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LAST_WORD = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4) - 33'd4;

   state_e             state_q;
   logic [CNT_W-1:0]   count_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic               write_q;
   logic               respValid_q;
   logic               respErr_q;
   logic               loadOk_q;

   logic               accept;
   logic               enterResp;
   logic               legal;
   logic [31:0]        curAddr;
   logic [31:0]        curWdata;
   logic               curWrite;
   logic [31:0]        offset;
   logic [IDX_W-1:0]   memIdx;
   logic               memWe;
   logic               memRe;
   logic [WORD_W-1:0]  arrayRdata;

   // In IDLE the live request is used directly so a LATENCY of 1 can commit on the accept edge.
   always_comb begin
      accept    = req_valid && (state_q == IDLE);
      curAddr   = addr_q;
      curWdata  = wdata_q;
      curWrite  = write_q;
      if (state_q == IDLE) begin
         curAddr  = req_addr;
         curWdata = req_wdata;
         curWrite = req_write;
      end
      enterResp = (accept && (LATENCY == 1)) ||
                  ((state_q == WAIT) && (count_q == CNT_W'(1)));
      legal     = addrLegal(curAddr, BASE_ADDR, LAST_WORD);
      offset    = curAddr - BASE_ADDR;
      memIdx    = IDX_W'(offset >> 2);
      memWe     = enterResp && curWrite && legal && !reset;
      memRe     = enterResp && !curWrite && legal && !reset;
   end

   // Request sequencing: latch on accept, count down the latency, pulse the response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         respValid_q <= 1'b0;
         respErr_q   <= 1'b0;
         loadOk_q    <= 1'b0;
      end else begin
         respValid_q <= enterResp;
         if (enterResp) begin
            respErr_q <= !legal;
            loadOk_q  <= legal && !curWrite;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  write_q <= req_write;
                  count_q <= CNT_W'(LATENCY - 1);
                  state_q <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               count_q <= count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   mem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk_i   (clk),
      .we_i    (memWe),
      .re_i    (memRe),
      .idx_i   (memIdx),
      .wdata_i (curWdata),
      .rdata_o (arrayRdata)
   );

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign resp_valid = respValid_q;
   assign resp_err   = respErr_q;
   assign resp_rdata = loadOk_q ? arrayRdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (LATENCY 2, 1, 15)
// share request data lines but have their own valid; expected responses are
// queued at issue time and popped by an independent monitor.
module tb_data_mem_responder;

   logic        clock;
   logic        reset;
   logic [2:0]  reqValid;
   logic [2:0]  reqReady;
   logic        reqWrite;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic [2:0]  respValid;
   logic [2:0]  respErr;
   logic [2:0]  busy;
   logic [31:0] respRdata [3];

   int compared   = 0;
   int mismatched = 0;
   int lat [3]    = '{2, 1, 15};

   logic [32:0] expQ0 [$];
   logic [32:0] expQ1 [$];
   logic [32:0] expQ2 [$];

   data_mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut0 (
      .clk(clock), .reset(reset), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
      .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
      .resp_valid(respValid[0]), .resp_rdata(respRdata[0]), .resp_err(respErr[0]), .busy(busy[0]));

   data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(262144)) dut1 (
      .clk(clock), .reset(reset), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
      .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
      .resp_valid(respValid[1]), .resp_rdata(respRdata[1]), .resp_err(respErr[1]), .busy(busy[1]));

   data_mem_responder #(.LATENCY(15), .DEPTH_WORDS(262144)) dut2 (
      .clk(clock), .reset(reset), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
      .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
      .resp_valid(respValid[2]), .resp_rdata(respRdata[2]), .resp_err(respErr[2]), .busy(busy[2]));

   // Free-running clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something wedges beyond every bounded wait.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushExp(input int sel, input logic [32:0] e);
      case (sel)
         0: expQ0.push_back(e);
         1: expQ1.push_back(e);
         default: expQ2.push_back(e);
      endcase
   endtask

   task automatic popCompare(input int sel, input logic [32:0] got);
      logic [32:0] e;
      int sz;
      sz = (sel == 0) ? expQ0.size() : (sel == 1) ? expQ1.size() : expQ2.size();
      if (sz == 0) begin
         checkOutput($sformatf("unexpected resp dut%0d", sel), 32'd1, 32'd0);
      end else begin
         case (sel)
            0: e = expQ0.pop_front();
            1: e = expQ1.pop_front();
            default: e = expQ2.pop_front();
         endcase
         checkOutput($sformatf("resp_rdata dut%0d", sel), got[31:0], e[31:0]);
         checkOutput($sformatf("resp_err dut%0d", sel), {31'd0, got[32]}, {31'd0, e[32]});
      end
   endtask

   // Monitor: every resp_valid pulse is matched against the oldest queued expectation.
   always @(negedge clock) begin
      for (int s = 0; s < 3; s++) begin
         if (respValid[s]) popCompare(s, {respErr[s], respRdata[s]});
      end
   end

   // Issue one request to instance sel and check handshake timing around it.
   task automatic applyStimulus(input int sel, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] expData, input logic expErr);
      bit accepted;
      bit seen;
      int busyCyc;
      pushExp(sel, {expErr, expData});
      @(negedge clock);
      reqWrite      = wr;
      reqAddr       = a;
      reqWdata      = d;
      reqValid[sel] = 1'b1;
      accepted      = 1'b0;
      for (int i = 0; i < 50 && !accepted; i++) begin
         if (reqReady[sel]) accepted = 1'b1;
         else @(negedge clock);
      end
      if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1 reqValid[sel] = 1'b0;
      seen    = 1'b0;
      busyCyc = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clock);
         if (busy[sel]) busyCyc++;
         if (respValid[sel]) begin
            seen = 1'b1;
            checkOutput($sformatf("latency dut%0d", sel), c, lat[sel]);
         end
      end
      if (!seen) checkOutput("resp timeout", 32'd0, 32'd1);
      checkOutput($sformatf("busy cycles dut%0d", sel), busyCyc, lat[sel]);
      @(negedge clock);
      checkOutput("resp pulse width", {31'd0, respValid[sel]}, 32'd0);
      checkOutput("busy after resp", {31'd0, busy[sel]}, 32'd0);
   endtask

   initial begin
      logic [31:0] addrs [2];
      logic [31:0] datas [2];
      int acceptCyc [$];
      int k;
      int pulses;

      reset    = 1'b1;
      reqValid = '0;
      reqWrite = 1'b0;
      reqAddr  = '0;
      reqWdata = '0;

      // Reset state.
      @(negedge clock);
      checkOutput("reset resp_valid", {31'd0, respValid[0]}, 32'd0);
      checkOutput("reset resp_rdata", respRdata[0], 32'd0);
      checkOutput("reset resp_err", {31'd0, respErr[0]}, 32'd0);
      checkOutput("reset busy", {31'd0, busy[0]}, 32'd0);
      checkOutput("reset req_ready", {31'd0, reqReady[0]}, 32'd1);
      @(negedge clock);
      reset = 1'b0;

      // Seed a neighbour word, then the main store/load pair.
      applyStimulus(0, 1'b1, 32'h7FF00014, 32'h0BADF00D, 32'h0, 1'b0);
      applyStimulus(0, 1'b1, 32'h7FF00010, 32'hDEADBEEF, 32'h0, 1'b0);
      applyStimulus(0, 1'b0, 32'h7FF00010, 32'h0, 32'hDEADBEEF, 1'b0);
      applyStimulus(0, 1'b0, 32'h7FF00014, 32'h0, 32'h0BADF00D, 1'b0);

      // Illegal accesses: out of window and misaligned.
      applyStimulus(0, 1'b1, 32'h00000040, 32'hFFFFFFFF, 32'h0, 1'b1);
      applyStimulus(0, 1'b0, 32'h7FF00012, 32'h0, 32'h0, 1'b1);
      applyStimulus(0, 1'b0, 32'h7FF00010, 32'h0, 32'hDEADBEEF, 1'b0);

      // Edges of the 1024-word window.
      applyStimulus(0, 1'b1, 32'h7FF00FFC, 32'h55AA33CC, 32'h0, 1'b0);
      applyStimulus(0, 1'b0, 32'h7FF00FFC, 32'h0, 32'h55AA33CC, 1'b0);
      applyStimulus(0, 1'b0, 32'h7FF01000, 32'h0, 32'h0, 1'b1);
      applyStimulus(0, 1'b0, 32'h7FEFFFFC, 32'h0, 32'h0, 1'b1);

      // Back-to-back requests with valid held high.
      addrs[0] = 32'h7FF00010; datas[0] = 32'hDEADBEEF;
      addrs[1] = 32'h7FF00014; datas[1] = 32'h0BADF00D;
      k = 0;
      @(negedge clock);
      reqWrite    = 1'b0;
      reqAddr     = addrs[0];
      reqValid[0] = 1'b1;
      for (int c = 0; c < 40 && k < 4; c++) begin
         if (busy[0]) checkOutput("ready while busy", {31'd0, reqReady[0]}, 32'd0);
         if (reqReady[0]) begin
            pushExp(0, {1'b0, datas[k % 2]});
            acceptCyc.push_back(c);
            k++;
         end
         @(posedge clock);
         #1;
         if (k < 4) reqAddr = addrs[k % 2];
         else reqValid[0] = 1'b0;
         @(negedge clock);
      end
      reqValid[0] = 1'b0;
      checkOutput("held-valid accepts", k, 32'd4);
      for (int i = 1; i < acceptCyc.size(); i++) begin
         checkOutput("accept spacing", acceptCyc[i] - acceptCyc[i-1], 32'd3);
      end
      repeat (4) @(negedge clock);

      // Reset in the middle of a store drops it.
      applyStimulus(0, 1'b1, 32'h7FF00020, 32'hAAAA5555, 32'h0, 1'b0);
      applyStimulus(0, 1'b0, 32'h7FF00014, 32'h0, 32'h0BADF00D, 1'b0);
      @(negedge clock);
      reqWrite    = 1'b1;
      reqAddr     = 32'h7FF00020;
      reqWdata    = 32'h12345678;
      reqValid[0] = 1'b1;
      @(posedge clock);
      #1 reqValid[0] = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("mid-op reset busy", {31'd0, busy[0]}, 32'd0);
      checkOutput("mid-op reset resp_rdata", respRdata[0], 32'd0);
      checkOutput("mid-op reset resp_err", {31'd0, respErr[0]}, 32'd0);
      checkOutput("mid-op reset req_ready", {31'd0, reqReady[0]}, 32'd1);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (c == 2) reset = 1'b0;
         if (respValid[0]) pulses++;
      end
      checkOutput("resp pulses after reset", pulses, 32'd0);
      applyStimulus(0, 1'b0, 32'h7FF00020, 32'h0, 32'hAAAA5555, 1'b0);

      // LATENCY=1 instance, top word of a 1 MiB window.
      applyStimulus(1, 1'b1, 32'h7FFFFFFC, 32'hCAFEF00D, 32'h0, 1'b0);
      applyStimulus(1, 1'b0, 32'h7FFFFFFC, 32'h0, 32'hCAFEF00D, 1'b0);
      applyStimulus(1, 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b1);
      applyStimulus(1, 1'b1, 32'hFFFFFFFC, 32'h11111111, 32'h0, 1'b1);
      applyStimulus(1, 1'b0, 32'h7FFFFFFC, 32'h0, 32'hCAFEF00D, 1'b0);

      // LATENCY=15 instance, same top word.
      applyStimulus(2, 1'b1, 32'h7FFFFFFC, 32'h13579BDF, 32'h0, 1'b0);
      applyStimulus(2, 1'b0, 32'h7FFFFFFC, 32'h0, 32'h13579BDF, 1'b0);
      applyStimulus(2, 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b1);

      repeat (5) @(negedge clock);
      checkOutput("pending dut0", expQ0.size(), 32'd0);
      checkOutput("pending dut1", expQ1.size(), 32'd0);
      checkOutput("pending dut2", expQ2.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
